// File: rtl/barret_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barret_pkg
// Description : Constants and elaboration helpers for the Barrett reducer.
// Revision    : 1.0
// ============================================================================
package barret_pkg;

    localparam int c_q_2689  = 2689;
    localparam int c_q_3329  = 3329;
    localparam int c_q_7681  = 7681;
    localparam int c_q_12289 = 12289;

    function automatic int barret_qw(input int q);
        return $clog2(q);
    endfunction

    function automatic int barret_mw(input int q, input int iw);
        return iw - barret_qw(q) + 1;
    endfunction

    // Two guard bits hold the pre-correction residue, which stays below 3Q.
    function automatic int barret_rw(input int q);
        return barret_qw(q) + 2;
    endfunction

    function automatic longint barret_m(input int q, input int iw);
        return (longint'(1) << iw) / longint'(q);
    endfunction

endpackage : barret_pkg
`default_nettype wire

// File: rtl/barret_reduce_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : barret_reduce_pipe_if
// Description : Operand/result handshake bundle for the Barrett reducer.
// Revision    : 1.0
// ============================================================================
interface barret_reduce_pipe_if #(
    parameter int IW   = 23,
    parameter int QW   = 12,
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   din_a;
    logic [TAGW-1:0] tag_in;
    logic            out_valid;
    logic            out_ready;
    logic [QW-1:0]   dout_r;
    logic [TAGW-1:0] tag_out;
    logic            busy;

    modport master (
        output in_valid, din_a, tag_in, out_ready,
        input  in_ready, out_valid, dout_r, tag_out, busy
    );

    modport slave (
        input  in_valid, din_a, tag_in, out_ready,
        output in_ready, out_valid, dout_r, tag_out, busy
    );

endinterface : barret_reduce_pipe_if
`default_nettype wire

// File: rtl/barret_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : barret_pipe_reg
// Description : One valid+payload pipeline stage with load enable and
//               asynchronous active-low clear.
// Revision    : 1.0
// ============================================================================
module barret_pipe_reg #(
    parameter int W = 8
) (
    input  wire          clk,
    input  wire          rst_n,
    input  wire          i_en,
    input  wire          i_valid,
    input  wire  [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Bubbles load like items so the whole pipe moves as one shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : barret_pipe_reg
`default_nettype wire

// File: rtl/barret_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : barret_reduce_pipe
// Description : Three-stage Barrett reducer, dout_r = din_a mod Q, one result
//               per clock with valid/ready on both sides and a sideband tag.
// Revision    : 1.0
// ============================================================================
module barret_reduce_pipe
    import barret_pkg::*;
#(
    parameter int Q    = c_q_2689,
    parameter int IW   = 23,
    parameter int TAGW = 4
) (
    input  wire                  clk,
    input  wire                  rst_n,
    barret_reduce_pipe_if.slave  bus
);

    localparam int QW  = barret_qw(Q);
    localparam int MW  = barret_mw(Q, IW);
    localparam int RW  = barret_rw(Q);
    localparam int K   = IW;
    localparam int S1W = MW + IW + TAGW;
    localparam int S2W = RW + TAGW;
    localparam int S3W = QW + TAGW;

    localparam logic [MW-1:0] c_m    = MW'(barret_m(Q, IW));
    localparam logic [QW-1:0] c_q    = QW'(Q);
    localparam logic [RW-1:0] c_q_rw = RW'(Q);

    if ((Q % 2) == 0 || Q < 3 || Q >= 65536 || IW < 2 * QW - 1 || TAGW < 1) begin : g_param_check
        $error("barret_reduce_pipe: unsupported Q/IW/TAGW combination");
    end

    logic              w_adv;
    logic [IW+MW-1:0]  w_p;
    logic [MW-1:0]     w_q_est;

    logic              r_v1;
    logic [S1W-1:0]    r_s1;
    logic [MW-1:0]     w_s1_qest;
    logic [IW-1:0]     w_s1_din;
    logic [TAGW-1:0]   w_s1_tag;
    logic [MW+QW-1:0]  w_qprod;
    logic [RW-1:0]     w_r;

    logic              r_v2;
    logic [S2W-1:0]    r_s2;
    logic [RW-1:0]     w_s2_r;
    logic [TAGW-1:0]   w_s2_tag;
    logic [RW-1:0]     w_r1;
    logic [RW-1:0]     w_r2;

    logic              r_v3;
    logic [S3W-1:0]    r_s3;

    // A full output stage that is not being taken freezes every stage.
    assign w_adv = bus.out_ready | ~r_v3;

    // Stage 1: quotient estimate from the top bits of din_a * M.
    assign w_p     = (IW+MW)'(bus.din_a) * (IW+MW)'(c_m);
    assign w_q_est = MW'(w_p >> K);

    barret_pipe_reg #(.W(S1W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_adv),
        .i_valid (bus.in_valid),
        .i_data  ({w_q_est, bus.din_a, bus.tag_in}),
        .o_valid (r_v1),
        .o_data  (r_s1)
    );

    assign w_s1_qest = r_s1[S1W-1 -: MW];
    assign w_s1_din  = r_s1[TAGW +: IW];
    assign w_s1_tag  = r_s1[TAGW-1:0];

    // Stage 2: the true remainder is below 3Q, so modulo-2^RW arithmetic is exact.
    assign w_qprod = (MW+QW)'(w_s1_qest) * (MW+QW)'(c_q);
    assign w_r     = RW'(w_s1_din) - RW'(w_qprod);

    barret_pipe_reg #(.W(S2W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_adv),
        .i_valid (r_v1),
        .i_data  ({w_r, w_s1_tag}),
        .o_valid (r_v2),
        .o_data  (r_s2)
    );

    assign w_s2_r   = r_s2[S2W-1 -: RW];
    assign w_s2_tag = r_s2[TAGW-1:0];

    // Stage 3: two conditional subtractions bring [0, 3Q) into [0, Q).
    assign w_r1 = (w_s2_r >= c_q_rw) ? (w_s2_r - c_q_rw) : w_s2_r;
    assign w_r2 = (w_r1   >= c_q_rw) ? (w_r1   - c_q_rw) : w_r1;

    barret_pipe_reg #(.W(S3W)) u_s3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_adv),
        .i_valid (r_v2),
        .i_data  ({QW'(w_r2), w_s2_tag}),
        .o_valid (r_v3),
        .o_data  (r_s3)
    );

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v3;
    assign bus.dout_r    = r_s3[S3W-1 -: QW];
    assign bus.tag_out   = r_s3[TAGW-1:0];
    assign bus.busy      = r_v1 | r_v2 | r_v3;

endmodule : barret_reduce_pipe
`default_nettype wire

// File: tb/tb_barret_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_barret_reduce_pipe
// Description : Scoreboard bench running Q=2689/IW=23 and Q=3329/IW=24
//               reducers side by side on a shared stimulus stream.
// Revision    : 1.0
// ============================================================================
module tb_barret_reduce_pipe;
    import barret_pkg::*;

    localparam int QA   = c_q_2689;
    localparam int IWA  = 23;
    localparam int QB   = c_q_3329;
    localparam int IWB  = 24;
    localparam int TAGW = 4;
    localparam int QWA  = barret_qw(QA);
    localparam int QWB  = barret_qw(QB);

    typedef struct {
        int              res;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    barret_reduce_pipe_if #(.IW(IWA), .QW(QWA), .TAGW(TAGW)) bus_a ();
    barret_reduce_pipe_if #(.IW(IWB), .QW(QWB), .TAGW(TAGW)) bus_b ();

    barret_reduce_pipe #(.Q(QA), .IW(IWA), .TAGW(TAGW)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    barret_reduce_pipe #(.Q(QB), .IW(IWB), .TAGW(TAGW)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic [23:0]     drv_din;
    logic [TAGW-1:0] drv_tag;
    logic            drv_valid;
    logic            ready_force;
    logic            rnd_ready;
    logic            rnd_bit = 1'b1;
    int              exp_a_v;
    int              exp_b_v;
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc   = 0;
    int              infl_a = 0;
    int              infl_b = 0;
    exp_t            q_a[$];
    exp_t            q_b[$];

    wire out_ready_w = rnd_ready ? rnd_bit : ready_force;

    assign bus_a.in_valid  = drv_valid;
    assign bus_a.din_a     = drv_din[IWA-1:0];
    assign bus_a.tag_in    = drv_tag;
    assign bus_a.out_ready = out_ready_w;
    assign bus_b.in_valid  = drv_valid;
    assign bus_b.din_a     = drv_din;
    assign bus_b.tag_in    = drv_tag;
    assign bus_b.out_ready = out_ready_w;

    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboards: push on acceptance, compare the head whenever a result is shown.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete();
            infl_a = 0;
        end else begin
            check("busy_a", 64'(bus_a.busy), 64'(infl_a != 0));
            if (bus_a.out_valid) begin
                if (q_a.size() == 0) begin
                    check("spurious_a", 64'(bus_a.out_valid), 64'(0));
                end else begin
                    check("res_a", 64'(bus_a.dout_r), 64'(q_a[0].res));
                    check("tag_a", 64'(bus_a.tag_out), 64'(q_a[0].tag));
                    if (bus_a.out_ready) void'(q_a.pop_front());
                end
            end
            if (drv_valid && bus_a.in_ready) q_a.push_back('{exp_a_v, drv_tag});
            infl_a = infl_a + int'(drv_valid && bus_a.in_ready)
                            - int'(bus_a.out_valid && bus_a.out_ready);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_b.delete();
            infl_b = 0;
        end else begin
            check("busy_b", 64'(bus_b.busy), 64'(infl_b != 0));
            if (bus_b.out_valid) begin
                if (q_b.size() == 0) begin
                    check("spurious_b", 64'(bus_b.out_valid), 64'(0));
                end else begin
                    check("res_b", 64'(bus_b.dout_r), 64'(q_b[0].res));
                    check("tag_b", 64'(bus_b.tag_out), 64'(q_b[0].tag));
                    if (bus_b.out_ready) void'(q_b.pop_front());
                end
            end
            if (drv_valid && bus_b.in_ready) q_b.push_back('{exp_b_v, drv_tag});
            infl_b = infl_b + int'(drv_valid && bus_b.in_ready)
                            - int'(bus_b.out_valid && bus_b.out_ready);
        end
    end

    // A negative expectation means "use the reference model".
    task automatic send(input logic [23:0] d, input logic [TAGW-1:0] t, input int ea, input int eb);
        logic acc;
        acc       = 1'b0;
        drv_din   = d;
        drv_tag   = t;
        drv_valid = 1'b1;
        exp_a_v   = (ea >= 0) ? ea : int'(d[IWA-1:0] % 23'(QA));
        exp_b_v   = (eb >= 0) ? eb : int'(d % 24'(QB));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("send_accept", 64'(acc), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        drv_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q_a.size() == 0 && q_b.size() == 0 && !bus_a.busy && !bus_b.busy) break;
        end
        check("drain", 64'(q_a.size() + q_b.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input logic [23:0] d, input logic [TAGW-1:0] t, input int ea, input int eb);
        int n;
        n = 0;
        send(d, t, ea, eb);
        drv_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus_a.out_valid) break;
        end
        check("latency", 64'(n), 64'(3));
        drain();
    endtask

    task automatic check_reset_outs();
        check("rst_out_valid_a", 64'(bus_a.out_valid), 64'(0));
        check("rst_busy_a",      64'(bus_a.busy),      64'(0));
        check("rst_dout_a",      64'(bus_a.dout_r),    64'(0));
        check("rst_tag_a",       64'(bus_a.tag_out),   64'(0));
        check("rst_in_ready_a",  64'(bus_a.in_ready),  64'(1));
        check("rst_out_valid_b", 64'(bus_b.out_valid), 64'(0));
        check("rst_busy_b",      64'(bus_b.busy),      64'(0));
        check("rst_dout_b",      64'(bus_b.dout_r),    64'(0));
        check("rst_tag_b",       64'(bus_b.tag_out),   64'(0));
        check("rst_in_ready_b",  64'(bus_b.in_ready),  64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n       = 1'b0;
        drv_valid   = 1'b0;
        drv_din     = '0;
        drv_tag     = '0;
        exp_a_v     = 0;
        exp_b_v     = 0;
        ready_force = 1'b1;
        rnd_ready   = 1'b0;
        #3;
        check_reset_outs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        measure_latency(24'd1234, 4'h9, -1, -1);

        // Back-to-back stream; each send must be taken on its first cycle.
        c0 = cyc;
        for (int d = 0; d < QA; d++) send(24'(d), TAGW'(d), -1, -1);
        check("stream_rate", 64'(cyc - c0), 64'(QA));
        for (int d = QA; d < QA + 2000; d++) send(24'(d), TAGW'(d), -1, -1);
        for (int d = QA + 2000; d < 8388608; d += 4099) send(24'(d), TAGW'(d), -1, -1);

        send(24'd0,        4'h0, 0,    -1);
        send(24'd2688,     4'h1, 2688, -1);
        send(24'd2689,     4'h2, 0,    -1);
        send(24'd7228031,  4'h3, 2688, -1);
        send(24'd7228032,  4'h4, 0,    -1);
        send(24'd8388607,  4'h5, 1616, -1);
        send(24'd11075584, 4'h6, -1,   1);
        send(24'd3329,     4'h7, -1,   0);
        send(24'd16777215, 4'h8, -1,   -1);
        drain();

        // Backpressure: three items fill the pipe, the fourth must wait.
        ready_force = 1'b0;
        fork
            begin
                send(24'd1000003, 4'd1, -1, -1);
                send(24'd7228031, 4'd2, -1, -1);
                send(24'd13462,   4'd3, -1, -1);
                send(24'd123,     4'd4, -1, -1);
                drv_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bus_a.out_valid) break;
                end
                #1;
                check("bp_in_ready", 64'(bus_a.in_ready), 64'(0));
                check("bp_held", 64'(q_a.size()), 64'(3));
                repeat (6) @(posedge clk);
                #1 ready_force = 1'b1;
            end
        join
        drain();

        // Reset with all three stages occupied.
        for (int i = 0; i < 4; i++) send(24'(777 + 1000 * i), TAGW'(i + 10), -1, -1);
        drv_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        measure_latency(24'd5381, 4'h5, 3, -1);

        // Random in_valid / out_ready, roughly half duty each.
        rnd_ready = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1) == 0) idle(1);
            send(24'($urandom), TAGW'($urandom), -1, -1);
        end
        drain();
        rnd_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_barret_reduce_pipe
`default_nettype wire
